// File: rtl/gs_pkg.sv
// Shared definitions for the GS sound-core memory subsystem.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: owner enum for the memory slot scheduler, address/data widths,
//           default slot timing constants reused by the core top-level and benches.
package gs_pkg;

  localparam int GS_AW             = 21;  // 2 MB external GS memory
  localparam int GS_DW             = 8;
  localparam int GS_CE_DIV_DEF     = 4;   // CLK cycles per GS slot
  localparam int GS_MEM_LAT_DEF    = 2;   // MEM_RD to valid MEM_DI
  localparam int GS_STARVE_MAX_DEF = 8;   // denied slots before loader is forced in

  // Who owns the memory port for the current slot
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_GS   = 2'd1,
    OWN_LD   = 2'd2
  } owner_e;

endpackage

// File: rtl/gs_mem_sched_if.sv
// Bundle of the GS core, host loader and external memory signals around gs_mem_sched.
// Latency: n/a (wires only).
// Backpressure: loader uses LD_REQ held until LD_ACK; GS core is stalled via GS_CE.
// Modports: master = scheduler view (drives CE, read data, ACK, memory command);
//           slave  = environment view (GS core, loader and memory model).
interface gs_mem_sched_if;
  import gs_pkg::*;

  // GS core side
  logic             GS_CE;
  logic [GS_AW-1:0] GS_MA;
  logic [GS_DW-1:0] GS_MDO;
  logic             GS_MRD_n;
  logic             GS_MWE_n;
  logic [GS_DW-1:0] GS_MDI;
  // host loader side
  logic             LD_REQ;
  logic             LD_WE;
  logic [GS_AW-1:0] LD_ADDR;
  logic [GS_DW-1:0] LD_DI;
  logic             LD_ACK;
  logic [GS_DW-1:0] LD_DO;
  // external memory side
  logic [GS_AW-1:0] MEM_A;
  logic [GS_DW-1:0] MEM_DO;
  logic             MEM_RD;
  logic             MEM_WE;
  logic [GS_DW-1:0] MEM_DI;

  modport master (
    output GS_CE, GS_MDI, LD_ACK, LD_DO, MEM_A, MEM_DO, MEM_RD, MEM_WE,
    input  GS_MA, GS_MDO, GS_MRD_n, GS_MWE_n, LD_REQ, LD_WE, LD_ADDR, LD_DI, MEM_DI
  );

  modport slave (
    input  GS_CE, GS_MDI, LD_ACK, LD_DO, MEM_A, MEM_DO, MEM_RD, MEM_WE,
    output GS_MA, GS_MDO, GS_MRD_n, GS_MWE_n, LD_REQ, LD_WE, LD_ADDR, LD_DI, MEM_DI
  );

endinterface

// File: rtl/gs_mem_sched_slot_timer.sv
// gs_slot_timer: free-running slot phase counter 0..CE_DIV-1 with phase strobes.
// Latency: strobes are decoded from the registered phase, valid in the phase they name.
// Backpressure: none; runs continuously, returns to phase 0 on RESET.
// Ports: CLK, RESET (sync, active-high); phase_start (phase 0), phase_cap (phase MEM_LAT),
//        phase_end (phase CE_DIV-1).
module gs_slot_timer
  import gs_pkg::*;
#(
  parameter int CE_DIV  = GS_CE_DIV_DEF,
  parameter int MEM_LAT = GS_MEM_LAT_DEF
) (
  input  logic CLK,
  input  logic RESET,
  output logic phase_start,
  output logic phase_cap,
  output logic phase_end
);

  localparam int PW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  logic [PW-1:0] phase_q, phase_d;

  always_comb begin
    phase_start = (phase_q == '0);
    phase_cap   = (phase_q == PW'(MEM_LAT));
    phase_end   = (phase_q == PW'(CE_DIV - 1));
    phase_d     = phase_end ? '0 : phase_q + PW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/gs_mem_sched.sv
// gs_mem_sched: time-slot arbiter sharing one GS memory port between the GS Z80 and a host loader.
// Latency: command in phase 0 of a slot, read data / LD_ACK in phase MEM_LAT+1, GS_CE in phase CE_DIV-1.
// Backpressure: GS is stalled by withholding GS_CE for a slot; loader waits with LD_REQ held until LD_ACK.
// Ports: CLK, RESET (sync, active-high); bus = gs_mem_sched_if.master (GS_*, LD_*, MEM_* signals).
// Build option: define GS_MEM_SCHED_FAIR_EN to force the loader in after STARVE_MAX denied slots;
//               without it GS has strict priority and the loader may starve.
module gs_mem_sched
  import gs_pkg::*;
#(
  parameter int CE_DIV     = GS_CE_DIV_DEF,
  parameter int MEM_LAT    = GS_MEM_LAT_DEF,
  parameter int STARVE_MAX = GS_STARVE_MAX_DEF
) (
  input logic            CLK,
  input logic            RESET,
  gs_mem_sched_if.master bus
);

  // Read data must be captured and acknowledged before the slot ends
  if ((MEM_LAT < 1) || (CE_DIV < MEM_LAT + 2)) begin : g_bad_timing
    $error("gs_mem_sched: need MEM_LAT >= 1 and CE_DIV >= MEM_LAT+2");
  end
  if ((STARVE_MAX < 1) || (STARVE_MAX > 15)) begin : g_bad_starve
    $error("gs_mem_sched: STARVE_MAX must fit the 4-bit starve counter (1..15)");
  end

  logic phase_start, phase_cap, phase_end;

  gs_slot_timer #(
    .CE_DIV  (CE_DIV),
    .MEM_LAT (MEM_LAT)
  ) u_timer (
    .CLK         (CLK),
    .RESET       (RESET),
    .phase_start (phase_start),
    .phase_cap   (phase_cap),
    .phase_end   (phase_end)
  );

  owner_e           owner_q, owner_d, slot_owner;
  logic             stall_q, stall_d;     // GS_CE withheld this slot
  logic             rd_q, rd_d;           // this slot issued a read
  logic             ld_ack_q, ld_ack_d;
  logic [GS_AW-1:0] mem_a_q, mem_a_d, cmd_a;
  logic [GS_DW-1:0] mem_do_q, mem_do_d, cmd_do;
  logic [GS_DW-1:0] gs_mdi_q, gs_mdi_d;
  logic [GS_DW-1:0] ld_do_q, ld_do_d;
  logic             gs_need, force_ld, cmd_vld, cmd_we;
`ifdef GS_MEM_SCHED_FAIR_EN
  logic [3:0]       starve_q, starve_d;
`endif

  // Slot decision. Only meaningful in phase 0; the GS inputs are stable for the
  // whole slot because the core only advances on GS_CE.
  always_comb begin
    gs_need  = ~bus.GS_MRD_n | ~bus.GS_MWE_n;
    force_ld = 1'b0;
`ifdef GS_MEM_SCHED_FAIR_EN
    force_ld = bus.LD_REQ & (starve_q >= 4'(STARVE_MAX));
`endif
    if (force_ld)        slot_owner = OWN_LD;
    else if (gs_need)    slot_owner = OWN_GS;
    else if (bus.LD_REQ) slot_owner = OWN_LD;
    else                 slot_owner = OWN_NONE;

    // GS write wins when both strobes are low, so RD and WE are mutually exclusive
    cmd_we = 1'b0;
    if (slot_owner == OWN_GS)      cmd_we = ~bus.GS_MWE_n;
    else if (slot_owner == OWN_LD) cmd_we = bus.LD_WE;

    cmd_a   = (slot_owner == OWN_LD) ? bus.LD_ADDR : bus.GS_MA;
    cmd_do  = (slot_owner == OWN_LD) ? bus.LD_DI   : bus.GS_MDO;
    cmd_vld = phase_start & ~RESET & (slot_owner != OWN_NONE);
  end

  always_comb begin
    owner_d  = owner_q;
    stall_d  = stall_q;
    rd_d     = rd_q;
    mem_a_d  = mem_a_q;
    mem_do_d = mem_do_q;
    gs_mdi_d = gs_mdi_q;
    ld_do_d  = ld_do_q;
    ld_ack_d = phase_cap & (owner_q == OWN_LD);
`ifdef GS_MEM_SCHED_FAIR_EN
    starve_d = starve_q;
`endif

    if (phase_start) begin
      owner_d = slot_owner;
      stall_d = (slot_owner == OWN_LD) & gs_need;
      rd_d    = cmd_vld & ~cmd_we;
      if (cmd_vld) begin
        mem_a_d  = cmd_a;
        mem_do_d = cmd_do;
      end
`ifdef GS_MEM_SCHED_FAIR_EN
      if (!bus.LD_REQ || (slot_owner == OWN_LD)) starve_d = 4'd0;
      else if (starve_q != 4'hF)                 starve_d = starve_q + 4'd1;
`endif
    end

    // Writes leave MEM_DI undefined, so only read slots update the read registers
    if (phase_cap && rd_q) begin
      if (owner_q == OWN_GS)      gs_mdi_d = bus.MEM_DI;
      else if (owner_q == OWN_LD) ld_do_d  = bus.MEM_DI;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      owner_q  <= OWN_NONE;
      stall_q  <= 1'b0;
      rd_q     <= 1'b0;
      ld_ack_q <= 1'b0;
      mem_a_q  <= '0;
      mem_do_q <= '0;
      gs_mdi_q <= 8'hFF;
      ld_do_q  <= 8'h00;
`ifdef GS_MEM_SCHED_FAIR_EN
      starve_q <= 4'd0;
`endif
    end else begin
      owner_q  <= owner_d;
      stall_q  <= stall_d;
      rd_q     <= rd_d;
      ld_ack_q <= ld_ack_d;
      mem_a_q  <= mem_a_d;
      mem_do_q <= mem_do_d;
      gs_mdi_q <= gs_mdi_d;
      ld_do_q  <= ld_do_d;
`ifdef GS_MEM_SCHED_FAIR_EN
      starve_q <= starve_d;
`endif
    end
  end

  // The command is issued in the same phase-0 cycle the decision is made,
  // then address/data are held from the registers until the next command.
  assign bus.MEM_RD = cmd_vld & ~cmd_we;
  assign bus.MEM_WE = cmd_vld & cmd_we;
  assign bus.MEM_A  = cmd_vld ? cmd_a  : mem_a_q;
  assign bus.MEM_DO = cmd_vld ? cmd_do : mem_do_q;
  assign bus.GS_CE  = phase_end & ~stall_q & ~RESET;
  assign bus.GS_MDI = gs_mdi_q;
  assign bus.LD_ACK = ld_ack_q;
  assign bus.LD_DO  = ld_do_q;

endmodule

// File: tb/tb_gs_mem_sched.sv
// Self-checking bench for gs_mem_sched: directed scenarios followed by random GS/loader traffic,
// checked cycle by cycle against a slot-level reference model and a behavioural memory.
module tb_gs_mem_sched;
  import gs_pkg::*;

  localparam int CE_DIV     = GS_CE_DIV_DEF;
  localparam int MEM_LAT    = GS_MEM_LAT_DEF;
  localparam int STARVE_MAX = GS_STARVE_MAX_DEF;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  gs_mem_sched_if bus();

  gs_mem_sched #(
    .CE_DIV     (CE_DIV),
    .MEM_LAT    (MEM_LAT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // GS core request: 0 internal cycle, 1 read, 2 write, 3 both strobes low
  int          gs_kind = 0;
  logic [20:0] gs_addr = '0;
  logic [7:0]  gs_data = '0;
  bit          ld_req = 0, ld_we = 0;
  logic [20:0] ld_addr = '0;
  logic [7:0]  ld_di = '0;

  logic [7:0]  mem_arr [int];
  logic [20:0] m_mem_a;
  logic [7:0]  m_mem_do, m_gs_mdi, m_ld_do;
  int          m_starve;
  bit          slot_ce, slot_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mem_val(input logic [20:0] a);
    if (mem_arr.exists(int'(a))) return mem_arr[int'(a)];
    return a[7:0] ^ 8'h3C;
  endfunction

  task automatic model_reset();
    m_mem_a  = '0;
    m_mem_do = '0;
    m_gs_mdi = 8'hFF;
    m_ld_do  = 8'h00;
    m_starve = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gs_ce"},  32'(bus.GS_CE),  32'd0);
    chk({tag, "_mem_rd"}, 32'(bus.MEM_RD), 32'd0);
    chk({tag, "_mem_we"}, 32'(bus.MEM_WE), 32'd0);
    chk({tag, "_ld_ack"}, 32'(bus.LD_ACK), 32'd0);
    chk({tag, "_mem_a"},  32'(bus.MEM_A),  32'd0);
    chk({tag, "_mem_do"}, 32'(bus.MEM_DO), 32'd0);
    chk({tag, "_gs_mdi"}, 32'(bus.GS_MDI), 32'hFF);
    chk({tag, "_ld_do"},  32'(bus.LD_DO),  32'h00);
  endtask

  task automatic drive_inputs();
    bus.GS_MA    = gs_addr;
    bus.GS_MDO   = gs_data;
    bus.GS_MRD_n = !(gs_kind == 1 || gs_kind == 3);
    bus.GS_MWE_n = !(gs_kind == 2 || gs_kind == 3);
    bus.LD_REQ   = ld_req;
    bus.LD_WE    = ld_we;
    bus.LD_ADDR  = ld_addr;
    bus.LD_DI    = ld_di;
  endtask

  // One slot, entered #1 after the edge that starts phase 0. abort_phase >= 0
  // raises RESET in that phase and returns after its edge.
  task automatic run_slot(input int abort_phase);
    bit need, force_ld, ld_own, gs_own, we, rd;
    logic [20:0] a;
    logic [7:0]  d, rdv, new_mdi, new_do;
    drive_inputs();
    need     = (gs_kind != 0);
    force_ld = 0;
`ifdef GS_MEM_SCHED_FAIR_EN
    force_ld = ld_req && (m_starve >= STARVE_MAX);
`endif
    ld_own = force_ld || (!need && ld_req);
    gs_own = need && !ld_own;
    if (ld_req && !ld_own) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
    else                   m_starve = 0;
    we = gs_own ? (gs_kind >= 2) : (ld_own ? ld_we : 1'b0);
    rd = (gs_own || ld_own) && !we;
    a  = ld_own ? ld_addr : gs_addr;
    d  = ld_own ? ld_di : gs_data;
    rdv     = mem_val(a);
    new_mdi = (gs_own && rd) ? rdv : m_gs_mdi;
    new_do  = (ld_own && rd) ? rdv : m_ld_do;
    slot_ce  = !(ld_own && need);
    slot_ack = ld_own;
    if (gs_own || ld_own) begin
      m_mem_a  = a;
      m_mem_do = d;
    end
    if (we) mem_arr[int'(a)] = d;
    for (int p = 0; p < CE_DIV; p++) begin
      bus.MEM_DI = (p == MEM_LAT && rd) ? rdv : 8'($urandom);
      if (p == abort_phase) RESET = 1'b1;
      @(negedge CLK);
      chk("mem_rd", 32'(bus.MEM_RD), 32'(p == 0 && rd));
      chk("mem_we", 32'(bus.MEM_WE), 32'(p == 0 && we));
      chk("mem_a",  32'(bus.MEM_A),  32'(m_mem_a));
      chk("mem_do", 32'(bus.MEM_DO), 32'(m_mem_do));
      chk("gs_ce",  32'(bus.GS_CE),  32'(p == CE_DIV - 1 && slot_ce));
      chk("ld_ack", 32'(bus.LD_ACK), 32'(p == MEM_LAT + 1 && slot_ack));
      chk("gs_mdi", 32'(bus.GS_MDI), 32'(p > MEM_LAT ? new_mdi : m_gs_mdi));
      chk("ld_do",  32'(bus.LD_DO),  32'(p > MEM_LAT ? new_do : m_ld_do));
      @(posedge CLK);
      #1;
      if (p == abort_phase) break;
    end
    m_gs_mdi = new_mdi;
    m_ld_do  = new_do;
  endtask

  task automatic pick_ops();
    if (slot_ce) begin
      gs_kind = $urandom_range(0, 3);
      gs_addr = {5'($urandom), 12'h000, 4'($urandom)};
      gs_data = 8'($urandom);
    end
    if (slot_ack || !ld_req) begin
      ld_req  = ($urandom_range(0, 1) == 1);
      ld_we   = ($urandom_range(0, 1) == 1);
      ld_addr = {5'($urandom), 12'h000, 4'($urandom)};
      ld_di   = 8'($urandom);
    end else if ($urandom_range(0, 7) == 0) begin
      ld_req = 0;  // withdrawn before grant
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int grant_slot;
    model_reset();
    drive_inputs();
    bus.MEM_DI = '0;
    RESET = 1'b1;

    // reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_reset_vals("rst");
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // GS reads with an idle loader, two consecutive slots
    mem_arr[int'(21'h010000)] = 8'h5A;
    gs_kind = 1; gs_addr = 21'h010000; gs_data = 8'h11; ld_req = 0;
    run_slot(-1);
    chk("tp1_gs_mdi", 32'(bus.GS_MDI), 32'h5A);
    run_slot(-1);

    // GS internal cycle, loader write to the top address
    gs_kind = 0;
    ld_req = 1; ld_we = 1; ld_addr = 21'h1FFFFF; ld_di = 8'hC3;
    run_slot(-1);
    chk("tp2_ack_seen", 32'(slot_ack), 32'd1);

    // Contention: GS first, loader on the next slot without gs_need
    gs_kind = 1; gs_addr = 21'h000123;
    ld_req = 1; ld_we = 0; ld_addr = 21'h1FFFFF;
    run_slot(-1);
    gs_kind = 0;
    run_slot(-1);
    chk("tp3_ld_do", 32'(bus.LD_DO), 32'hC3);
    ld_req = 0;

    // Both GS strobes low is a write; read it back
    gs_kind = 3; gs_addr = 21'h000777; gs_data = 8'h99;
    run_slot(-1);
    gs_kind = 1;
    run_slot(-1);
    chk("tp4_readback", 32'(bus.GS_MDI), 32'h99);

    // GS writes every slot while the loader waits for a read
    ld_req = 1; ld_we = 0; ld_addr = 21'h000777;
    grant_slot = 0;
    for (int s = 1; s <= 12; s++) begin
      gs_kind = 2; gs_addr = {5'($urandom), 12'h000, 4'($urandom)}; gs_data = 8'($urandom);
      run_slot(-1);
      if (slot_ack) begin
        grant_slot = s;
        break;
      end
    end
`ifdef GS_MEM_SCHED_FAIR_EN
    chk("fair_grant_slot", 32'(grant_slot), 32'(STARVE_MAX + 1));
    chk("fair_ld_do", 32'(bus.LD_DO), 32'h99);
    ld_req = 0;
    run_slot(-1);  // stalled GS write retried with the same address
    chk("fair_retry_ce", 32'(slot_ce), 32'd1);
`else
    chk("strict_no_grant", 32'(grant_slot), 32'd0);
    ld_req = 0;
`endif

    // Random traffic
    slot_ce = 1; slot_ack = 1;
    for (int s = 0; s < 250; s++) begin
      pick_ops();
      run_slot(-1);
    end

    // RESET at phase 1 of a loader read
    gs_kind = 0; ld_req = 1; ld_we = 0; ld_addr = 21'h000777;
    run_slot(1);
    model_reset();
    @(negedge CLK);
    chk_reset_vals("abort");
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk_reset_vals("abort_hold");
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    run_slot(-1);
    chk("post_rst_ack", 32'(slot_ack), 32'd1);
    chk("post_rst_ld_do", 32'(bus.LD_DO), 32'h99);
    ld_req = 0;
    run_slot(-1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
